// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier: one Booth digit per cycle, WIDTH/2+1 cycles per product.
// Handles signed or unsigned operands by extending both to WIDTH+2 bits when the operation is accepted.
module booth_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int EW   = WIDTH + 2;
  localparam int UW   = WIDTH + 3;
  localparam int PW   = UW + EW + 1;
  localparam int CW   = $clog2(ITER);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] step;
  logic [EW-1:0] mcand;
  logic [PW-1:0] prod;

  logic [EW-1:0] aExt;
  logic [EW-1:0] bExt;
  logic [UW-1:0] aPos;
  logic [UW-1:0] a2Pos;
  logic [UW-1:0] ppAdd;
  logic [UW-1:0] upperSum;
  logic [PW-1:0] prodNext;

  // The two guard bits let a full-range unsigned operand look positive to the Booth recoder.
  always_comb begin
    aExt = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    bExt = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
  end

  assign aPos  = {mcand[EW-1], mcand};
  assign a2Pos = {mcand, 1'b0};

  // prod[2:0] holds the current Booth digit {b[2i+1], b[2i], b[2i-1]}.
  always_comb begin
    ppAdd = '0;
    case (prod[2:0])
      3'b001, 3'b010: ppAdd = aPos;
      3'b011:         ppAdd = a2Pos;
      3'b100:         ppAdd = -a2Pos;
      3'b101, 3'b110: ppAdd = -aPos;
      default:        ppAdd = '0;
    endcase
  end

  always_comb begin
    upperSum = prod[PW-1 -: UW] + ppAdd;
    prodNext = $signed({upperSum, prod[EW:0]}) >>> 2;
  end

  // Control and datapath; DONE accepts a new start just like IDLE so operations can run back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      step   <= '0;
      mcand  <= '0;
      prod   <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand <= aExt;
            prod  <= {{UW{1'b0}}, bExt, 1'b0};
            step  <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          prod <= prodNext;
          if (step == CW'(ITER - 1)) begin
            result <= prodNext[2*WIDTH:1];
            state  <= DONE;
          end else begin
            step <= step + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed bench for booth_seq_multiplier at WIDTH=32 and WIDTH=8, with expected products queued at stimulus time.
module tb_booth_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;

  logic        start, isSigned;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] result;

  logic        start8, isSigned8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] result8;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acceptCyc, acceptCyc8;
  int doneCyc = 0;
  int prevDoneCyc = 0;
  logic [63:0] q32[$];
  logic [15:0] q8[$];

  booth_seq_multiplier #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start), .is_signed(isSigned),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  booth_seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(isSigned8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .result(result8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h required=0x%0h", tag, obs, exp);
    end
  endtask

  // Start is held for 'hold' extra cycles with scrambled operands that must be ignored.
  task automatic applyStimulus(input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                               input logic [63:0] expv, input int hold);
    @(negedge clk);
    start = 1'b1; isSigned = sgn; a = av; b = bv;
    q32.push_back(expv);
    @(posedge clk);
    #1;
    acceptCyc = cyc;
    checkOutput("busy_after_accept", 64'(busy), 64'd1);
    checkOutput("done_low_after_accept", 64'(done), 64'd0);
    repeat (hold) begin
      @(negedge clk);
      a = $urandom; b = $urandom; isSigned = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic waitDone(input int expLat, input logic checkFall);
    int n = 0;
    logic seen = 1'b0;
    logic [63:0] expv;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    checkOutput("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      expv = q32.pop_front();
      checkOutput("result", result, expv);
      checkOutput("latency", 64'(cyc - acceptCyc), 64'(expLat));
      checkOutput("busy_low_at_done", 64'(busy), 64'd0);
      prevDoneCyc = doneCyc;
      doneCyc = cyc;
      if (checkFall) begin
        @(posedge clk);
        #1;
        checkOutput("done_pulse_width", 64'(done), 64'd0);
      end
    end
  endtask

  task automatic applyStimulus8(input logic sgn, input logic [7:0] av, input logic [7:0] bv,
                                input logic [15:0] expv);
    @(negedge clk);
    start8 = 1'b1; isSigned8 = sgn; a8 = av; b8 = bv;
    q8.push_back(expv);
    @(posedge clk);
    #1;
    acceptCyc8 = cyc;
    checkOutput("busy8_after_accept", 64'(busy8), 64'd1);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic waitDone8(input int expLat);
    int n = 0;
    logic seen = 1'b0;
    logic [15:0] expv;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done8 === 1'b1) seen = 1'b1;
    end
    checkOutput("done8_seen", 64'(seen), 64'd1);
    if (seen) begin
      expv = q8.pop_front();
      checkOutput("result8", 64'(result8), 64'(expv));
      checkOutput("latency8", 64'(cyc - acceptCyc8), 64'(expLat));
      @(posedge clk);
      #1;
      checkOutput("done8_pulse_width", 64'(done8), 64'd0);
    end
  endtask

  initial begin
    int spurious;
    rst = 1'b1;
    start = 1'b0; isSigned = 1'b0; a = '0; b = '0;
    start8 = 1'b0; isSigned8 = 1'b0; a8 = '0; b8 = '0;
    #12;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_result", result, 64'd0);
    checkOutput("reset_result8", 64'(result8), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b1, 32'd50, 32'hFFFFFFD8, 64'hFFFFFFFF_FFFFF830, 0);
    waitDone(17, 1'b1);
    applyStimulus(1'b0, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, 0);
    waitDone(17, 1'b1);
    applyStimulus(1'b1, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE, 0);
    waitDone(17, 1'b1);
    applyStimulus(1'b1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 0);
    waitDone(17, 1'b1);
    applyStimulus(1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, 0);
    waitDone(17, 1'b1);

    applyStimulus(1'b1, 32'hFFFFFC19, 32'd999, 64'hFFFFFFFF_FFF0C58F, 10);
    waitDone(17, 1'b1);

    applyStimulus(1'b0, 32'd3, 32'd4, 64'd12, 0);
    waitDone(17, 1'b0);
    applyStimulus(1'b1, 32'd98765, 32'd1, 64'h00000000_000181CD, 0);
    waitDone(17, 1'b1);
    checkOutput("b2b_period", 64'(doneCyc - prevDoneCyc), 64'd18);

    // Abort mid-operation: the queued expectation is dropped since no done may follow.
    applyStimulus(1'b1, 32'hFFFFFE0C, 32'd2000, 64'hFFFFFFFF_FFF0BDC0, 0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_result", result, 64'd0);
    void'(q32.pop_back());
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) spurious++;
    end
    checkOutput("quiet_after_abort", 64'(spurious), 64'd0);
    applyStimulus(1'b1, 32'hFFFFFE0C, 32'd2000, 64'hFFFFFFFF_FFF0BDC0, 0);
    waitDone(17, 1'b1);

    applyStimulus8(1'b1, 8'h80, 8'h7F, 16'hC080);
    waitDone8(5);
    applyStimulus8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
    waitDone8(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/booth_seq_multiplier.md
# booth_seq_multiplier

Parametrised, iterative radix-4 Booth multiplier producing a full-width 2·WIDTH product from two WIDTH-bit operands. Each operand pair can be treated as two's-complement or as unsigned. This is the sequential, area-reduced successor to the combinational 32×32 signed multiplier, built for datapaths that can tolerate a fixed multi-cycle latency. It sits behind a start/done handshake and holds its result until the next operation completes.

## Interface
- WIDTH, 32: operand width. Must be even and ≥ 4. Product width is 2·WIDTH.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only when the block is able to accept (IDLE or DONE).
- is_signed  input  1  1 = a and b are two's-complement; 0 = both unsigned. Sampled with start.
- a  input  WIDTH  multiplicand. Sampled with start.
- b  input  WIDTH  multiplier. Sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: result is valid.
- result  output  2·WIDTH  product. Held stable from done until the next done.

## Operation
- Operand extension: at accept, a and b are extended to WIDTH+2 bits. The extension uses sign-extension when is_signed=1 and zero-extension when is_signed=0. This makes an unsigned full-range operand correct under Booth recoding.
- Iteration count: ITER = WIDTH/2 + 1 radix-4 steps (17 for WIDTH=32).
- Per step, the multiplier digit is recoded from 3 bits {b[2i+1], b[2i], b[2i−1]} (b[−1]=0) into a partial product of 0, ±A, or ±2A.
  - The partial product is added into a (WIDTH+3)-bit accumulator upper half.
  - The combined accumulator/multiplier register is then arithmetic-shifted right by 2.
- result is the low 2·WIDTH bits of the final accumulator. The product is exact for every input in both modes; there is no overflow.
- State machine: IDLE → RUN → DONE.
  - IDLE: busy=0, done=0. start=1 latches is_signed, a and b, clears the step counter, and moves to RUN.
  - RUN: busy=1. One Booth step per cycle. After step ITER−1, result is registered and the state moves to DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1 in DONE is accepted as in IDLE and goes directly to RUN (back-to-back operation).
    - Otherwise the state moves to IDLE.
- start while in RUN is ignored. Operand changes during RUN have no effect.
- Zero operands take the full latency; there is no early termination.

## Timing
- Reset values: busy=0, done=0, result=0, state=IDLE, step counter=0. Reset takes effect immediately, asynchronously.
- Reset mid-operation aborts the operation. result returns to 0 and no done pulse is produced. The first start accepted after rst deasserts begins a fresh operation.
- Latency: start sampled at edge E0.
  - busy is high after E0.
  - At edge E0+ITER, result updates, busy falls and done rises.
  - At E0+ITER+1, done falls (unless a new start was also accepted there).
- WIDTH=32: done is high in the cycle after edge E0+17.
- Throughput: back-to-back starts give one result every ITER+1 cycles.
- busy and done are never high in the same cycle.
- result changes only at the edge where done rises, or on reset.

## Test plan
- WIDTH=32, signed, a=50, b=−40 (0xFFFFFFD8) → result=0xFFFFFFFF_FFFFF830 (−2000). done pulses exactly 1 cycle, 17 edges after start.
- WIDTH=32, a=0xFFFFFFFF, b=2:
  - is_signed=0 → 0x00000001_FFFFFFFE.
  - is_signed=1 → 0xFFFFFFFF_FFFFFFFE.
- WIDTH=32, signed corners:
  - a=b=0x80000000 → 0x40000000_00000000.
  - a=0x7FFFFFFF, b=0x80000000 → 0xC0000000_80000000.
- Handshake:
  - start held high across RUN with changing a/b → only the first operands are used; −999·999 gives 0xFFFFFFFF_FFF0C58F.
  - A start in the done cycle with 98765·1 → second done after ITER+1 cycles with 0x181CD.
- Reset: assert rst at step 5 of −500·2000 → busy/done/result = 0 immediately, no done pulse afterward. A re-issued operation gives 0xFFFFFFFF_FFF0BDC0.
- WIDTH=8:
  - signed −128·127 → 0xC080, done after 5 edges.
  - unsigned 255·255 → 0xFE01.
